mem_requester: RTL and testbench
================================

// Module: mem_requester
// PURPOSE
//  Bus-master side of the 8-bit CPU memory interface: accepts fetch/load/store
//  requests from the CPU core over a valid/ready handshake, drives address,
//  write data and write strobe to the 256-byte memory, and waits out its
//  synchronous read latency. Checks access rights against the memory map
//  (ROM 0x00-0x7F, data RAM, IO-in 0xE0-0xEF, IO-out 0xF0-0xFF) and returns
//  read data or a fault code. One request in flight at a time.
// PARAMETERS
//  ROM_SIZE    128  bytes of program ROM at 0x00; fetch legal only below this
//  IO_IN_BASE  224  first IO-input address; [IO_IN_BASE, IO_IN_BASE+16) not writable
//  READ_LAT    1    memory read latency in cycles after ISSUE (legal 1..7)
// PORTS
//  clk          in   1  single clock, rising edge
//  reset        in   1  asynchronous, active-high
//  req_valid    in   1  core request present
//  req_ready    out  1  block can accept a request (high only in IDLE)
//  req_op       in   2  00 fetch, 01 load, 10 store, 11 reserved
//  req_addr     in   8  byte address
//  req_wdata    in   8  store data
//  resp_valid   out  1  response present; held until resp_ready
//  resp_ready   in   1  core accepts response
//  resp_rdata   out  8  read data (fetch/load); 0 for store or fault
//  resp_fault   out  2  00 ok, 01 illegal op, 10 fetch >= ROM_SIZE, 11 protected store
//  mem_address  out  8  address to memory (registered)
//  mem_data_in  out  8  write data to memory (registered)
//  mem_write    out  1  write strobe, one cycle per store
//  mem_data_out in   8  read data from memory
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, req_ready=1, resp_valid=0,
//   resp_rdata=0, resp_fault=0, mem_address=0, mem_data_in=0, mem_write=0.
//   In-flight request is dropped; a store in ISSUE is aborted (strobe drops at once).
//  FSM IDLE -> ISSUE -> [WAIT] -> RESP -> IDLE.
//  IDLE: req_ready=1. On req_valid at edge: latch op/addr/wdata, classify:
//   op 11 -> fault 01; fetch with addr >= ROM_SIZE -> fault 10; store with
//   addr < ROM_SIZE or in IO-in range -> fault 11. Fault -> RESP directly, no
//   memory access (mem_write stays 0, mem_address unchanged). Else -> ISSUE.
//  ISSUE (1 cycle): mem_address=addr. Store: mem_write=1, mem_data_in=wdata,
//   next RESP. Fetch/load: mem_write=0, wait counter=READ_LAT, next WAIT.
//  WAIT: counter decrements each cycle; at the edge where it reaches 0,
//   resp_rdata <= mem_data_out, go RESP. Exactly READ_LAT cycles in WAIT.
//  RESP: resp_valid=1, resp_rdata/resp_fault stable; leave on resp_ready
//   (same edge) to IDLE. resp_valid falls, req_ready rises the next cycle;
//   no request accepted in the RESP cycle (no back-to-back overlap).
//  Latency (accept edge = T): fault resp at T+1; store resp at T+2 with
//   mem_write high during T+1; fetch/load resp at T+2+READ_LAT.
//  mem_address/mem_data_in hold last driven value outside ISSUE; mem_write
//   high only in ISSUE of a legal store. Loads/stores to IO-out and RAM legal;
//   loads from any address legal. Address arithmetic is 8-bit, no wrap logic.
//  req_* ignored outside IDLE; changes to them after acceptance have no effect.
// TESTING
//  Reset mid-WAIT of a load -> next cycle all outputs at reset values, req_ready=1, no resp.
//  Store op=10 addr=0x80 wdata=0x5A -> mem_write=1 one cycle, mem_address=0x80,
//   mem_data_in=0x5A; resp_fault=00 at T+2.
//  Load addr=0x80 after that store, READ_LAT=1 -> resp_rdata=0x5A, fault=00 at T+3;
//   repeat with READ_LAT=3 -> resp at T+5.
//  Fetch addr=0x90 -> fault 10 at T+1, mem_write never asserted; fetch 0x7F -> ok.
//  Store to 0x10 and to 0xE5 -> fault 11, no strobe; store to 0xF0 -> ok; op=11 -> fault 01.
//  Hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0,
//   req_valid pulses ignored; release -> IDLE next cycle.

Source files
------------

// File: rtl/mem_requester_if.sv
// Core-side request/response handshake plus the memory bus of the 8-bit CPU.
// The requester is the master; the core and memory together form the slave side.
interface mem_requester_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_rdata;
    logic [1:0] resp_fault;
    logic [7:0] mem_address;
    logic [7:0] mem_data_in;
    logic       mem_write;
    logic [7:0] mem_data_out;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_address, mem_data_in, mem_write
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_address, mem_data_in, mem_write
    );
endinterface

// File: rtl/mem_requester.sv
// Single-outstanding memory requester: checks access rights against the memory
// map, drives the registered memory bus and returns read data or a fault code.
module mem_requester #(
    parameter int ROM_SIZE   = 128,
    parameter int IO_IN_BASE = 224,
    parameter int READ_LAT   = 1
) (
    input logic             clk,
    input logic             reset,
    mem_requester_if.master bus
);
    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;
    localparam logic [1:0] F_OK     = 2'b00;
    localparam logic [1:0] F_OP     = 2'b01;
    localparam logic [1:0] F_ROM    = 2'b10;
    localparam logic [1:0] F_PROT   = 2'b11;
    localparam logic [8:0] ROM_LIM  = 9'(ROM_SIZE);
    localparam logic [8:0] IO_LO    = 9'(IO_IN_BASE);
    localparam logic [8:0] IO_HI    = 9'(IO_IN_BASE + 16);
    localparam logic [2:0] LAT      = 3'(READ_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state, state_d;
    logic       store_q, store_d;
    logic [2:0] cnt, cnt_d;
    logic       mem_write_d;
    logic [7:0] addr_d, wdata_d, rdata_d;
    logic [1:0] fault_d, fault_code;

    // Nine-bit compares keep the IO window upper bound (base + 16) representable.
    function automatic logic [1:0] classify(input logic [1:0] op, input logic [7:0] addr);
        logic [8:0] a;
        a = {1'b0, addr};
        if (op == OP_RSVD)
            return F_OP;
        if (op == OP_FETCH && a >= ROM_LIM)
            return F_ROM;
        if (op == OP_STORE && (a < ROM_LIM || (a >= IO_LO && a < IO_HI)))
            return F_PROT;
        return F_OK;
    endfunction

    assign fault_code     = classify(bus.req_op, bus.req_addr);
    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);

    always_comb begin
        state_d     = state;
        store_d     = store_q;
        cnt_d       = cnt;
        mem_write_d = bus.mem_write;
        addr_d      = bus.mem_address;
        wdata_d     = bus.mem_data_in;
        rdata_d     = bus.resp_rdata;
        fault_d     = bus.resp_fault;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    store_d = (bus.req_op == OP_STORE);
                    rdata_d = '0;
                    fault_d = fault_code;
                    if (fault_code != F_OK) begin
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                        addr_d  = bus.req_addr;
                        if (bus.req_op == OP_STORE) begin
                            mem_write_d = 1'b1;
                            wdata_d     = bus.req_wdata;
                        end
                    end
                end
            end
            ISSUE: begin
                mem_write_d = 1'b0;
                if (store_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = LAT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Leaving on the edge where the counter hits zero gives exactly READ_LAT wait cycles.
                if (cnt <= 3'd1) begin
                    cnt_d   = '0;
                    rdata_d = bus.mem_data_out;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt - 3'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_q         <= 1'b0;
            cnt             <= '0;
            bus.mem_write   <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_data_in <= '0;
            bus.resp_rdata  <= '0;
            bus.resp_fault  <= '0;
        end else begin
            store_q         <= store_d;
            cnt             <= cnt_d;
            bus.mem_write   <= mem_write_d;
            bus.mem_address <= addr_d;
            bus.mem_data_in <= wdata_d;
            bus.resp_rdata  <= rdata_d;
            bus.resp_fault  <= fault_d;
        end
    end
endmodule

// File: tb/tb_mem_requester.sv
// Randomized scoreboard bench for mem_requester: two instances (read latency 1 and 3)
// share one memory model and are exercised one at a time through a select mux.
module tb_mem_requester;
    localparam int ROM = 128;
    localparam int IOB = 224;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sel = 1'b0;
    logic       mem_clr = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = '0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rr_rand = 1'b1;
    logic       hold = 1'b0;
    logic       always_rdy = 1'b0;
    logic       resp_ready_w;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    typedef struct {
        logic [1:0] fault;
        logic [7:0] rdata;
        int         d;
        int         acc;
        logic       store;
    } exp_t;
    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    exp_t sb_q[$];
    wr_t  wr_q[$];
    logic [7:0] ref_mem [256];

    // Memory model: unwritten bytes read as a fixed pattern; reads are pipelined.
    logic [7:0]   mem [256];
    logic [255:0] wv;
    logic [7:0]   p1;
    logic [7:0]   p3 [3];

    mem_requester_if bus1();
    mem_requester_if bus3();

    mem_requester #(.ROM_SIZE(128), .IO_IN_BASE(224), .READ_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    mem_requester #(.ROM_SIZE(128), .IO_IN_BASE(224), .READ_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3));

    function automatic logic [7:0] init_val(input int a);
        return 8'(a * 13 + 7);
    endfunction

    function automatic logic [7:0] rd(input logic [7:0] a);
        return wv[a] ? mem[a] : init_val(int'(a));
    endfunction

    assign resp_ready_w = !hold && (always_rdy || rr_rand);

    assign bus1.req_valid  = req_valid & ~sel;
    assign bus3.req_valid  = req_valid & sel;
    assign bus1.req_op     = req_op;
    assign bus3.req_op     = req_op;
    assign bus1.req_addr   = req_addr;
    assign bus3.req_addr   = req_addr;
    assign bus1.req_wdata  = req_wdata;
    assign bus3.req_wdata  = req_wdata;
    assign bus1.resp_ready = resp_ready_w & ~sel;
    assign bus3.resp_ready = resp_ready_w & sel;
    assign bus1.mem_data_out = p1;
    assign bus3.mem_data_out = p3[2];

    logic       m_req_ready, m_resp_valid, m_mem_write;
    logic [7:0] m_resp_rdata, m_mem_address, m_mem_data_in;
    logic [1:0] m_resp_fault;
    assign m_req_ready   = sel ? bus3.req_ready   : bus1.req_ready;
    assign m_resp_valid  = sel ? bus3.resp_valid  : bus1.resp_valid;
    assign m_resp_rdata  = sel ? bus3.resp_rdata  : bus1.resp_rdata;
    assign m_resp_fault  = sel ? bus3.resp_fault  : bus1.resp_fault;
    assign m_mem_write   = sel ? bus3.mem_write   : bus1.mem_write;
    assign m_mem_address = sel ? bus3.mem_address : bus1.mem_address;
    assign m_mem_data_in = sel ? bus3.mem_data_in : bus1.mem_data_in;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_clr) begin
            wv <= '0;
        end else begin
            if (bus1.mem_write) begin
                mem[bus1.mem_address] <= bus1.mem_data_in;
                wv[bus1.mem_address]  <= 1'b1;
            end
            if (bus3.mem_write) begin
                mem[bus3.mem_address] <= bus3.mem_data_in;
                wv[bus3.mem_address]  <= 1'b1;
            end
        end
        p1    <= rd(bus1.mem_address);
        p3[0] <= rd(bus3.mem_address);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    always @(posedge clk) begin
        #2;
        rr_rand = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: access rules of the memory map, applied directly to the address.
    function automatic exp_t model(input logic [1:0] op, input logic [7:0] addr, input int lat);
        exp_t e;
        int   a;
        a       = int'(addr);
        e.store = (op == 2'b10);
        e.acc   = 0;
        e.rdata = '0;
        if (op == 2'b11)                                           e.fault = 2'b01;
        else if (op == 2'b00 && a >= ROM)                          e.fault = 2'b10;
        else if (op == 2'b10 && (a < ROM || (a >= IOB && a < IOB + 16))) e.fault = 2'b11;
        else                                                       e.fault = 2'b00;
        if (e.fault != 2'b00)   e.d = 0;
        else if (op == 2'b10)   e.d = 1;
        else begin
            e.d     = 1 + lat;
            e.rdata = ref_mem[addr];
        end
        return e;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (m_req_ready) begin
                ok = 1'b1;
                return;
            end
        end
        chk("ready_timeout", int'(m_req_ready), 1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata);
        exp_t e;
        bit   ok;
        wait_ready(ok);
        if (!ok) return;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        e     = model(op, addr, sel ? 3 : 1);
        e.acc = cyc;
        if (e.store && e.fault == 2'b00) begin
            wr_q.push_back('{addr, wdata});
            ref_mem[addr] = wdata;
        end
        sb_q.push_back(e);
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0 && m_req_ready) return;
        end
        chk("drain_timeout", sb_q.size(), 0);
    endtask

    task automatic rand_issue(input int n);
        logic [7:0] picks [11];
        picks = '{8'h00, 8'h7F, 8'h80, 8'h90, 8'hDF, 8'hE0, 8'hE5, 8'hEF, 8'hF0, 8'hFF, 8'h81};
        for (int i = 0; i < n; i++) begin
            int k;
            logic [7:0] a;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            k = $urandom_range(0, 14);
            a = (k < 11) ? picks[k] : 8'($urandom);
            issue(2'($urandom_range(0, 3)), a, 8'($urandom));
        end
    endtask

    task automatic clear_sb();
        sb_q.delete();
        wr_q.delete();
    endtask

    // Monitor: samples on the falling edge, pops expectations on each new response.
    initial begin
        exp_t       e;
        wr_t        w;
        logic       in_resp;
        logic [7:0] held_rdata;
        logic [1:0] held_fault;
        in_resp    = 1'b0;
        held_rdata = '0;
        held_fault = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_resp = 1'b0;
            end else begin
                if (m_mem_write) begin
                    if (wr_q.size() == 0) begin
                        chk("unexpected_strobe", int'(m_mem_write), 0);
                    end else begin
                        w = wr_q.pop_front();
                        chk("strobe_addr", int'(m_mem_address), int'(w.addr));
                        chk("strobe_data", int'(m_mem_data_in), int'(w.data));
                    end
                end
                if (m_resp_valid) begin
                    if (in_resp) begin
                        chk("held_rdata", int'(m_resp_rdata), int'(held_rdata));
                        chk("held_fault", int'(m_resp_fault), int'(held_fault));
                    end else if (sb_q.size() == 0) begin
                        chk("unexpected_resp", int'(m_resp_valid), 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("resp_fault", int'(m_resp_fault), int'(e.fault));
                        chk("resp_rdata", int'(m_resp_rdata), int'(e.rdata));
                        chk("resp_latency", cyc - e.acc, e.d);
                        if (e.store && e.fault == 2'b00)
                            chk("store_strobe_seen", wr_q.size(), 0);
                        held_rdata = m_resp_rdata;
                        held_fault = m_resp_fault;
                    end
                    in_resp = !resp_ready_w;
                end else begin
                    in_resp = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] old;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        repeat (2) @(posedge clk);
        #3;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_req_ready",   int'(m_req_ready), 1);
            chk("rst_resp_valid",  int'(m_resp_valid), 0);
            chk("rst_resp_rdata",  int'(m_resp_rdata), 0);
            chk("rst_resp_fault",  int'(m_resp_fault), 0);
            chk("rst_mem_address", int'(m_mem_address), 0);
            chk("rst_mem_data_in", int'(m_mem_data_in), 0);
            chk("rst_mem_write",   int'(m_mem_write), 0);
        end
        @(posedge clk); #1;
        sel     = 1'b0;
        mem_clr = 1'b0;
        reset   = 1'b0;

        // Directed map checks on the latency-1 instance.
        issue(2'b10, 8'h80, 8'h5A);
        issue(2'b01, 8'h80, 8'h00);
        issue(2'b00, 8'h90, 8'h00);
        issue(2'b00, 8'h7F, 8'h00);
        issue(2'b10, 8'h10, 8'hA1);
        issue(2'b10, 8'hE5, 8'hA2);
        issue(2'b10, 8'hF0, 8'h33);
        issue(2'b11, 8'h20, 8'h00);
        issue(2'b01, 8'hF0, 8'h00);
        drain();

        // Latency-3 instance: read-back, then reset in the middle of a load wait.
        sel = 1'b1;
        issue(2'b01, 8'h80, 8'h00);
        issue(2'b01, 8'h44, 8'h00);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        clear_sb();
        chk("midwait_req_ready",  int'(m_req_ready), 1);
        chk("midwait_resp_valid", int'(m_resp_valid), 0);
        chk("midwait_rdata",      int'(m_resp_rdata), 0);
        chk("midwait_mem_addr",   int'(m_mem_address), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("no_resp_after_reset", int'(m_resp_valid), 0);
        rand_issue(25);
        drain();

        sel = 1'b0;
        rand_issue(45);
        drain();

        // Response back-pressure: pending response must hold and requests be ignored.
        hold = 1'b1;
        issue(2'b01, 8'h80, 8'h00);
        for (int i = 0; i < 20 && !m_resp_valid; i++) @(negedge clk);
        chk("hold_resp_seen", int'(m_resp_valid), 1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_req_ready", int'(m_req_ready), 0);
            req_valid = 1'b1;
            req_op    = 2'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = 8'($urandom);
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        hold       = 1'b0;
        always_rdy = 1'b1;
        @(posedge clk); #1;
        chk("release_resp_valid", int'(m_resp_valid), 0);
        chk("release_req_ready",  int'(m_req_ready), 1);
        always_rdy = 1'b0;

        // Reset during the strobe cycle of a store aborts the write.
        old = ref_mem[8'hF3];
        issue(2'b10, 8'hF3, 8'hC4);
        reset = 1'b1;
        #1;
        chk("abort_strobe", int'(m_mem_write), 0);
        clear_sb();
        ref_mem[8'hF3] = old;
        @(posedge clk); #1;
        reset = 1'b0;
        issue(2'b01, 8'hF3, 8'h00);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
